// File: rtl/muldiv_unit.sv
// ============================================================================
// muldiv_unit: iterative RV-style multiply/divide (radix-2 shift-add multiply,
// restoring divide) with IDLE/CALC/DONE control and valid/ready handshakes.
// Revision: 1.0
// ============================================================================
`default_nettype none

module muldiv_unit #(
  parameter int XLEN      = 32,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] operand2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            div_by_zero,
  output logic            busy
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]     count;
  logic [2*XLEN-1:0] acc;       // mul: {partial, multiplier}; div: {remainder, quotient}
  logic [XLEN-1:0]   opb;       // multiplicand or divisor magnitude
  logic [2:0]        op;
  logic              neg_main;
  logic              neg_rem;
  logic              dz_pend;

  // ---------------- request decode ----------------
  logic            is_div, is_rem, sgn1, sgn2, a_neg, b_neg;
  logic            div_zero, div_ovf, early, accept, last_step;
  logic [XLEN-1:0] a_mag, b_mag, early_res;

  always_comb begin
    sgn1 = 1'b0;
    sgn2 = 1'b0;
    case (func3)
      3'b000, 3'b001, 3'b100, 3'b110: begin sgn1 = 1'b1; sgn2 = 1'b1; end
      3'b010:                         sgn1 = 1'b1;
      default:                        ;
    endcase
  end

  assign is_div    = func3[2];
  assign is_rem    = func3[1];
  assign a_neg     = sgn1 & operand1[XLEN-1];
  assign b_neg     = sgn2 & operand2[XLEN-1];
  assign a_mag     = a_neg ? -operand1 : operand1;
  assign b_mag     = b_neg ? -operand2 : operand2;
  assign div_zero  = is_div && (operand2 == '0);
  assign div_ovf   = is_div && sgn1 && (operand1 == {1'b1, {(XLEN-1){1'b0}}}) &&
                     (operand2 == '1);
  assign early     = EARLY_OUT && (div_zero || div_ovf);
  assign early_res = is_rem ? (div_zero ? operand1 : '0) : (div_zero ? '1 : operand1);
  assign accept    = in_valid && in_ready;
  assign last_step = (count == CW'(XLEN - 1));

  // ---------------- one iteration step ----------------
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] step_next;

  assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
  assign div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, opb};

  always_comb begin
    if (op[2]) begin
      if (!div_diff[XLEN])
        step_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else
        step_next = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end else begin
      step_next = {mul_sum, acc[XLEN-1:1]};
    end
  end

  // ---------------- sign correction and result select ----------------
  logic [2*XLEN-1:0] prod_c;
  logic [XLEN-1:0]   quot_c, rem_c, final_res;

  assign prod_c = neg_main ? -step_next : step_next;
  assign quot_c = dz_pend ? '1 :
                  (neg_main ? -step_next[XLEN-1:0] : step_next[XLEN-1:0]);
  assign rem_c  = neg_rem ? -step_next[2*XLEN-1:XLEN] : step_next[2*XLEN-1:XLEN];

  always_comb begin
    final_res = prod_c[XLEN-1:0];
    case (op)
      3'b001, 3'b010, 3'b011: final_res = prod_c[2*XLEN-1:XLEN];
      3'b100, 3'b101:         final_res = quot_c;
      3'b110, 3'b111:         final_res = rem_c;
      default:                final_res = prod_c[XLEN-1:0];
    endcase
  end

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)    state_next = early ? DONE : CALC;
      CALC:    if (last_step) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  assign in_ready  = (state == IDLE) && !flush;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      acc         <= '0;
      opb         <= '0;
      op          <= '0;
      neg_main    <= 1'b0;
      neg_rem     <= 1'b0;
      dz_pend     <= 1'b0;
      result      <= '0;
      div_by_zero <= 1'b0;
    end else if (!flush) begin
      case (state)
        IDLE: if (accept) begin
          count    <= '0;
          op       <= func3;
          neg_main <= a_neg ^ b_neg;
          neg_rem  <= a_neg;
          dz_pend  <= div_zero;
          acc      <= is_div ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
          opb      <= is_div ? b_mag : a_mag;
          if (early) begin
            result      <= early_res;
            div_by_zero <= div_zero;
          end
        end
        CALC: begin
          acc   <= step_next;
          count <= count + CW'(1);
          if (last_step) begin
            result      <= final_res;
            div_by_zero <= dz_pend;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
